// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: operand-source encoding,
// per-stage shadow record and the register-match helper.
package hazard_pkg;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_info_t;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  function automatic logic stage_hit(stage_info_t s, logic [DEF_REG_AW-1:0] rs, logic used);
    return s.valid && s.reg_write && (s.rd == rs) && (rs != '0) && used;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Priority compare of one source register against the EX/MEM/WB shadow entries.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [DEF_REG_AW-1:0] i_rs,
  input  logic                  i_rs_used,
  input  stage_info_t           i_ex,
  input  stage_info_t           i_mem,
  input  stage_info_t           i_wb,
  output fwd_sel_t              o_sel,
  output logic                  o_ex_hit
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = stage_hit(i_ex,  i_rs, i_rs_used);
  assign w_mem_hit = stage_hit(i_mem, i_rs, i_rs_used);
  assign w_wb_hit  = stage_hit(i_wb,  i_rs, i_rs_used);

  // Youngest producer wins so the operand sees the most recent value.
  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit)       o_sel = FWD_EX;
    else if (w_mem_hit) o_sel = FWD_MEM;
    else if (w_wb_hit)  o_sel = FWD_WB;
  end

  assign o_ex_hit = w_ex_hit;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller: shadow EX/MEM/WB destination info drives
// operand mux selects, load-use stalls, branch flushes and a stall counter.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_branch_taken,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_count
);

  stage_info_t      r_ex;
  stage_info_t      r_mem;
  stage_info_t      r_wb;
  logic [CNT_W-1:0] r_stall_count;

  fwd_sel_t w_sel_a;
  fwd_sel_t w_sel_b;
  logic     w_ex_hit_a;
  logic     w_ex_hit_b;
  logic     w_load_use;
  logic     w_pc_write;
  logic     w_ifid_write;
  logic     w_ifid_flush;
  logic     w_idex_bubble;

  fwd_select u_fwd_a (
    .i_rs      (id_rs1),
    .i_rs_used (id_rs1_used & id_valid),
    .i_ex      (r_ex),
    .i_mem     (r_mem),
    .i_wb      (r_wb),
    .o_sel     (w_sel_a),
    .o_ex_hit  (w_ex_hit_a)
  );

  fwd_select u_fwd_b (
    .i_rs      (id_rs2),
    .i_rs_used (id_rs2_used & id_valid),
    .i_ex      (r_ex),
    .i_mem     (r_mem),
    .i_wb      (r_wb),
    .o_sel     (w_sel_b),
    .o_ex_hit  (w_ex_hit_b)
  );

  assign w_load_use = id_valid && r_ex.mem_read && (w_ex_hit_a || w_ex_hit_b);

  // A taken branch squashes the ID instruction, so it overrides any stall.
  always_comb begin
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    if (ex_branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
    end else if (w_load_use) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (id_valid && !w_idex_bubble) begin
        r_ex.valid     <= 1'b1;
        r_ex.rd        <= id_rd;
        r_ex.reg_write <= id_reg_write;
        r_ex.mem_read  <= id_mem_read;
      end else begin
        r_ex <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_load_use && !ex_branch_taken && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign fwd_a_sel   = w_sel_a;
  assign fwd_b_sel   = w_sel_b;
  assign pc_write    = w_pc_write;
  assign ifid_write  = w_ifid_write;
  assign ifid_flush  = w_ifid_flush;
  assign idex_bubble = w_idex_bubble;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench: directed vector table, reset/saturation sequences and
// randomized traffic against a pipeline-list reference model.
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       ex_branch_taken;

  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic [15:0] stall_count;

  logic [1:0] sat_fwd_a_sel;
  logic [1:0] sat_fwd_b_sel;
  logic       sat_pc_write;
  logic       sat_ifid_write;
  logic       sat_ifid_flush;
  logic       sat_idex_bubble;
  logic [1:0] sat_stall_count;

  int checks;
  int errors;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    int         ea;
    int         eb;
    int         epc;
    int         eifw;
    int         eflush;
    int         ebub;
    int         ecnt;
  } vec_t;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } mstage_t;

  vec_t    vecs[18];
  mstage_t pipe[3];
  int      mcnt;

  hazard_forward_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .stall_count     (stall_count)
  );

  hazard_forward_ctrl #(.CNT_W(2)) dut_sat (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .fwd_a_sel       (sat_fwd_a_sel),
    .fwd_b_sel       (sat_fwd_b_sel),
    .pc_write        (sat_pc_write),
    .ifid_write      (sat_ifid_write),
    .ifid_flush      (sat_ifid_flush),
    .idex_bubble     (sat_idex_bubble),
    .stall_count     (sat_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic v, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                 logic [4:0] rd, logic rw, logic mr, logic br,
                                 int ea, int eb, int epc, int eifw, int eflush, int ebub, int ecnt);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
    t.rd = rd; t.rw = rw; t.mr = mr; t.br = br;
    t.ea = ea; t.eb = eb; t.epc = epc; t.eifw = eifw;
    t.eflush = eflush; t.ebub = ebub; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one ID-stage record just after a falling edge, then let it settle.
  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    id_valid        = t.v;
    id_rs1          = t.rs1;
    id_rs2          = t.rs2;
    id_rs1_used     = t.u1;
    id_rs2_used     = t.u2;
    id_rd           = t.rd;
    id_reg_write    = t.rw;
    id_mem_read     = t.mr;
    ex_branch_taken = t.br;
    #1;
  endtask

  task automatic checkVec(input string tag, input vec_t t);
    checkOutput({tag, ".fwd_a"},  int'(fwd_a_sel),   t.ea);
    checkOutput({tag, ".fwd_b"},  int'(fwd_b_sel),   t.eb);
    checkOutput({tag, ".pc_wr"},  int'(pc_write),    t.epc);
    checkOutput({tag, ".ifid_w"}, int'(ifid_write),  t.eifw);
    checkOutput({tag, ".flush"},  int'(ifid_flush),  t.eflush);
    checkOutput({tag, ".bubble"}, int'(idex_bubble), t.ebub);
    checkOutput({tag, ".count"},  int'(stall_count), t.ecnt);
  endtask

  function automatic int modelSel(logic v, logic used, logic [4:0] rs);
    if (!v || !used || rs == 5'd0) return 0;
    for (int i = 0; i < 3; i++) begin
      if (pipe[i].v && pipe[i].rw && pipe[i].rd == rs) return i + 1;
    end
    return 0;
  endfunction

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vec_t t;
    vec_t idle;
    vec_t lw7;
    vec_t use7;
    checks = 0;
    errors = 0;
    reset  = 1'b1;

    idle = mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    lw7  = mkVec(1, 1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    use7 = mkVec(1, 2, 7, 1, 1, 8, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);

    vecs[0]  = mkVec(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0);
    vecs[1]  = mkVec(1, 1, 2, 1, 1,  5, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0);
    vecs[2]  = mkVec(1, 5, 6, 1, 1, 10, 1, 0, 0,  1, 0, 1, 1, 0, 0, 0);
    vecs[3]  = mkVec(1, 5, 0, 1, 0, 11, 1, 0, 0,  2, 0, 1, 1, 0, 0, 0);
    vecs[4]  = mkVec(1, 5, 0, 1, 0, 12, 1, 0, 0,  3, 0, 1, 1, 0, 0, 0);
    vecs[5]  = mkVec(1, 5, 0, 1, 0, 13, 1, 0, 0,  0, 0, 1, 1, 0, 0, 0);
    vecs[6]  = mkVec(1, 1, 0, 1, 0,  7, 1, 1, 0,  0, 0, 1, 1, 0, 0, 0);
    vecs[7]  = mkVec(1, 2, 7, 1, 1,  8, 1, 0, 0,  0, 1, 0, 0, 0, 1, 0);
    vecs[8]  = mkVec(1, 2, 7, 1, 1,  8, 1, 0, 0,  0, 2, 1, 1, 0, 0, 1);
    vecs[9]  = mkVec(1, 8, 0, 1, 0,  0, 1, 1, 0,  1, 0, 1, 1, 0, 0, 1);
    vecs[10] = mkVec(1, 0, 0, 1, 1,  9, 1, 0, 0,  0, 0, 1, 1, 0, 0, 1);
    vecs[11] = mkVec(1, 0, 0, 0, 0,  3, 1, 0, 0,  0, 0, 1, 1, 0, 0, 1);
    vecs[12] = mkVec(1, 9, 0, 1, 0,  3, 1, 0, 0,  2, 0, 1, 1, 0, 0, 1);
    vecs[13] = mkVec(1, 3, 3, 1, 1, 14, 1, 0, 0,  1, 1, 1, 1, 0, 0, 1);
    vecs[14] = mkVec(1, 0, 0, 0, 0,  4, 1, 1, 0,  0, 0, 1, 1, 0, 0, 1);
    vecs[15] = mkVec(1, 4, 3, 1, 1, 15, 1, 0, 1,  1, 3, 1, 1, 1, 1, 1);
    vecs[16] = mkVec(1, 4, 0, 1, 0,  0, 0, 0, 0,  2, 0, 1, 1, 0, 0, 1);
    vecs[17] = mkVec(0, 4, 4, 1, 1,  0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 1);

    // Outputs must sit at idle values while reset is held, even with a reader in ID.
    t = mkVec(1, 5, 7, 1, 1, 5, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(t);
    checkVec("reset_hold", t);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      checkVec($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a load-use stall.
    pulseReset();
    applyStimulus(lw7);
    applyStimulus(use7);
    checkOutput("rst_seq.stall_pc", int'(pc_write), 0);
    applyStimulus(lw7);
    applyStimulus(use7);
    checkOutput("rst_seq.stall_bub", int'(idex_bubble), 1);
    checkOutput("rst_seq.cnt_before", int'(stall_count), 1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid.pc_wr", int'(pc_write), 1);
    checkOutput("rst_mid.ifid_w", int'(ifid_write), 1);
    checkOutput("rst_mid.bubble", int'(idex_bubble), 0);
    checkOutput("rst_mid.fwd_b", int'(fwd_b_sel), 0);
    checkOutput("rst_mid.count", int'(stall_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // Four stalls into the 2-bit counter instance.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(lw7);
      applyStimulus(use7);
    end
    applyStimulus(idle);
    checkOutput("sat.count2", int'(sat_stall_count), 3);
    checkOutput("sat.count16", int'(stall_count), 4);

    // Randomized traffic against the pipeline-list model.
    pulseReset();
    for (int s = 0; s < 3; s++) pipe[s] = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      int  ea;
      int  eb;
      logic luse;
      logic bub;
      t.v   = ($urandom_range(0, 9) < 8);
      t.rs1 = 5'($urandom_range(0, 7));
      t.rs2 = 5'($urandom_range(0, 7));
      t.u1  = 1'($urandom_range(0, 1));
      t.u2  = 1'($urandom_range(0, 1));
      t.rd  = 5'($urandom_range(0, 7));
      t.rw  = ($urandom_range(0, 9) < 7);
      t.mr  = ($urandom_range(0, 9) < 3);
      t.br  = ($urandom_range(0, 9) < 1);
      applyStimulus(t);
      ea   = modelSel(t.v, t.u1, t.rs1);
      eb   = modelSel(t.v, t.u2, t.rs2);
      luse = pipe[0].mr && (ea == 1 || eb == 1);
      bub  = t.br || luse;
      checkOutput("rnd.fwd_a", int'(fwd_a_sel), ea);
      checkOutput("rnd.fwd_b", int'(fwd_b_sel), eb);
      checkOutput("rnd.pc_wr", int'(pc_write), int'(!bub || t.br));
      checkOutput("rnd.ifid_w", int'(ifid_write), int'(!bub || t.br));
      checkOutput("rnd.flush", int'(ifid_flush), int'(t.br));
      checkOutput("rnd.bubble", int'(idex_bubble), int'(bub));
      checkOutput("rnd.count", int'(stall_count), mcnt);
      checkOutput("rnd.count2", int'(sat_stall_count), (mcnt > 3) ? 3 : mcnt);
      if (luse && !t.br && mcnt < 65535) mcnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (t.v && !bub) pipe[0] = '{v: 1'b1, rd: t.rd, rw: t.rw, mr: t.mr};
      else             pipe[0] = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core.
- Keeps a shadow copy of the destination info for the instructions in EX, MEM and WB. From that copy it drives the select lines of the 2-to-1 mux chains on the decode-stage operands, plus the PC/IF-ID write enables and the ID/EX bubble.
- Inserts one-cycle load-use stalls and two-stage flushes on a taken branch.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  source register 1 of the ID instruction.
- id_rs2  in  REG_AW  source register 2 of the ID instruction.
- id_rs1_used  in  1  rs1 is read.
- id_rs2_used  in  1  rs2 is read.
- id_rd  in  REG_AW  destination of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- fwd_a_sel  out  2  rs1 operand source: 0 regfile, 1 EX ALU, 2 MEM result, 3 WB result.
- fwd_b_sel  out  2  rs2 operand source, same encoding.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to a NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Shadow state, one entry per stage (EX, MEM, WB): {valid, rd, reg_write, mem_read}. All entries clear to 0 on reset.
- Every clock edge: WB <= MEM, MEM <= EX.
  - EX <= ID fields when id_valid and not idex_bubble.
  - Otherwise EX <= invalid.
- Hit(stage, rs): stage.valid && stage.reg_write && stage.rd == rs && rs != 0 && the matching rs_used is 1.
- Forwarding (combinational from shadow state and ID inputs):
  - Priority EX (1) > MEM (2) > WB (3); no hit gives 0.
  - When id_valid = 0, both selects are 0.
- Load-use:
  - load_use = id_valid && EX.mem_read && (Hit(EX, rs1) || Hit(EX, rs2)).
  - On load_use: pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - Next cycle the load is in MEM, so the select becomes 2 and the stall releases. Each load-use stall therefore lasts exactly 1 cycle.
  - While load_use is active, fwd selects still reflect the priority rule; the bubbled ID/EX ignores them.
- Branch flush:
  - ex_branch_taken = 1 gives ifid_flush = 1, idex_bubble = 1, pc_write = 1, ifid_write = 1.
  - The EX shadow next cycle is invalid.
- Simultaneous load_use and ex_branch_taken: the flush wins. pc_write = 1, no stall is counted, and the ID instruction is squashed.
- Idle (no hazard): pc_write = 1, ifid_write = 1, ifid_flush = 0, idex_bubble = 0.
- stall_count:
  - Increments by 1 on each clock edge where load_use && !ex_branch_taken.
  - Saturates at 2^CNT_W - 1.
  - Registered output; resets to 0.
- Reset values:
  - All shadow entries invalid and stall_count = 0.
  - Combinational outputs during reset therefore evaluate to fwd 0/0, pc_write 1, ifid_write 1, ifid_flush 0, idex_bubble 0.
  - An asserted reset mid-stall clears EX immediately, which drops the stall in the same cycle.
- Register x0 never forwards and never stalls.

Decomposition:
- Package hazard_pkg:
  - fwd_sel_t enum: FWD_RF = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3.
  - stage_info_t struct: valid, rd, reg_write, mem_read.
  - REG_AW default constant.
- One sub-module, fwd_select: purely combinational priority compare of one rs against the three shadow entries, producing fwd_sel_t and an ex_hit flag. It is instantiated twice, for rs1 and rs2.

Test Plan:
- Back-to-back ALU: add x5 in ID, then the next ID reads rs1 = x5 -> fwd_a_sel = 1. One cycle later a third instruction reading x5 -> 2; next -> 3; next -> 0.
- Load-use: lw x7 followed by add rs2 = x7 -> one cycle of pc_write = 0, ifid_write = 0, idex_bubble = 1, stall_count 0 -> 1. Next cycle fwd_b_sel = 2 and pc_write = 1.
- x0 destination: instruction writing rd = 0, then a reader of x0 -> selects 0, no stall even when the writer is a load.
- Priority: EX and MEM both write x3, ID reads x3 on both operands -> fwd_a_sel = fwd_b_sel = 1.
- Flush vs stall: load x4 in EX, ID reads x4, ex_branch_taken = 1 in the same cycle -> ifid_flush = 1, idex_bubble = 1, pc_write = 1, stall_count unchanged.
- Reset and saturation:
  - Assert reset during a load-use stall -> outputs return to idle values in the same cycle and stall_count = 0.
  - With CNT_W = 2, four stalls leave the counter at 3.
